// File: rtl/full_adder4_pkg.sv
// Shared constants for the 4-bit registered ripple-carry adder.
package full_adder4_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

endpackage : full_adder4_pkg

// File: rtl/full_adder_1bit.sv
// One-bit combinational full adder cell used as a ripple-carry stage.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : full_adder_1bit

// File: rtl/full_adder4.sv
// Registered ripple-carry adder: {c_out, sum} = a + b + c_in, one cycle latency.
module full_adder4
    import full_adder4_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             c_out_d, c_out_q;
    logic             valid_d, valid_q;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder_1bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    // Result registers only load on valid input; otherwise they hold.
    always_comb begin
        sum_d   = sum_q;
        c_out_d = c_out_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d   = sum_comb;
            c_out_d = carry[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign out_valid = valid_q;

endmodule : full_adder4

// File: tb/tb_full_adder4.sv
// Scoreboard bench for full_adder4: driver queues expected output state, monitor compares.
module tb_full_adder4;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic       in_valid;
    logic [3:0] sum;
    logic       c_out;
    logic       out_valid;

    typedef struct {
        logic       v;
        logic [3:0] s;
        logic       c;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    bit   done;

    // Reference register state, derived from plain arithmetic.
    logic       m_v;
    logic [3:0] m_s;
    logic       m_c;

    full_adder4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .in_valid  (in_valid),
        .sum       (sum),
        .c_out     (c_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] aa,
                        input logic [3:0] bb, input logic cc);
        int unsigned tot;
        rst      = r;
        in_valid = v;
        a        = aa;
        b        = bb;
        c_in     = cc;
        if (r) begin
            m_v = 1'b0;
            m_s = 4'd0;
            m_c = 1'b0;
        end else if (v) begin
            tot = 32'(aa) + 32'(bb) + 32'(cc);
            m_s = tot[3:0];
            m_c = tot[4];
            m_v = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        sb.push_back('{m_v, m_s, m_c});
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected state per clock edge, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_valid", 32'(out_valid), 32'(e.v));
                check("sum", 32'(sum), 32'(e.s));
                check("c_out", 32'(c_out), 32'(e.c));
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        done     = 1'b0;
        m_v      = 1'b0;
        m_s      = 4'd0;
        m_c      = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        c_in     = 1'b0;

        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);

        step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);

        step(1'b0, 1'b1, 4'd3, 4'd4, 1'b0);
        step(1'b0, 1'b1, 4'd2, 4'd5, 1'b0);
        step(1'b0, 1'b1, 4'd9, 4'd9, 1'b0);
        step(1'b0, 1'b1, 4'd10, 4'd15, 1'b0);
        step(1'b0, 1'b1, 4'd10, 4'd5, 1'b1);

        step(1'b0, 1'b1, 4'd15, 4'd15, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

        // Reset dominates a simultaneous valid operand.
        step(1'b1, 1'b1, 4'd9, 4'd9, 1'b0);
        step(1'b0, 1'b0, 4'd3, 4'd3, 1'b0);

        for (int unsigned k = 0; k < 512; k++) begin
            logic [8:0] kv;
            kv = 9'(k);
            step(1'b0, 1'b1, kv[8:5], kv[4:1], kv[0]);
        end

        step(1'b0, 1'b1, 4'd7, 4'd8, 1'b1);
        step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 4'd6, 4'd6, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(15) == 0), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout got running expected finished");
            $fatal(1, "timeout");
        end
    end

endmodule : tb_full_adder4
